// File: rtl/masked_op_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : masked_op_reg                                                |
// | Description : WIDTH-bit datapath register with ACTIVE stored low bits and  |
// |               an op-coded update path (load, shift, rotate, inc/dec,      |
// |               clear) plus registered carry and zero flags. Upper          |
// |               WIDTH-ACTIVE bits always read as zero.                      |
// | Revision    : 1.0 - initial parametrised release                          |
// +----------------------------------------------------------------------------+
module masked_op_reg #(
  parameter int WIDTH  = 10,
  parameter int ACTIVE = 8
) (
  input  logic             clk,
  input  logic             reset,   // synchronous, active low
  input  logic             select,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] data,
  input  logic             ser_in,
  output logic [WIDTH-1:0] Q,
  output logic             carry,
  output logic             zero
);

  localparam logic [2:0] OP_HOLD = 3'd0;
  localparam logic [2:0] OP_LOAD = 3'd1;
  localparam logic [2:0] OP_SHL  = 3'd2;
  localparam logic [2:0] OP_SHR  = 3'd3;
  localparam logic [2:0] OP_INC  = 3'd4;
  localparam logic [2:0] OP_DEC  = 3'd5;
  localparam logic [2:0] OP_CLR  = 3'd6;
  localparam logic [2:0] OP_ROL  = 3'd7;

  logic [ACTIVE-1:0] r_q, r_d;
  logic              carry_q, carry_d;
  logic              zero_q;

  // Candidate results for the shift/rotate ops; a 1-bit register has no
  // R[A-2:0] slice, so shifts degenerate to taking ser_in and ROL to a no-op.
  logic [ACTIVE-1:0] w_shl, w_shr, w_rol;
  logic [ACTIVE:0]   w_inc;
  logic [ACTIVE-1:0] w_dec;

  generate
    if (ACTIVE == 1) begin : g_one_bit
      assign w_shl = ser_in;
      assign w_shr = ser_in;
      assign w_rol = r_q;
    end else begin : g_multi_bit
      assign w_shl = {r_q[ACTIVE-2:0], ser_in};
      assign w_shr = {ser_in, r_q[ACTIVE-1:1]};
      assign w_rol = {r_q[ACTIVE-2:0], r_q[ACTIVE-1]};
    end
  endgenerate

  assign w_inc = {1'b0, r_q} + (ACTIVE+1)'(1);
  assign w_dec = r_q - ACTIVE'(1);

  // Next-state decode for the stored bits and carry flag.
  always_comb begin
    r_d     = r_q;
    carry_d = carry_q;
    if (select) begin
      case (op)
        OP_HOLD: begin
          r_d     = r_q;
          carry_d = carry_q;
        end
        OP_LOAD: begin
          r_d     = data[ACTIVE-1:0];
          carry_d = 1'b0;
        end
        OP_SHL: begin
          r_d     = w_shl;
          carry_d = r_q[ACTIVE-1];
        end
        OP_SHR: begin
          r_d     = w_shr;
          carry_d = r_q[0];
        end
        OP_INC: begin
          r_d     = w_inc[ACTIVE-1:0];
          carry_d = w_inc[ACTIVE];
        end
        OP_DEC: begin
          r_d     = w_dec;
          carry_d = (r_q == '0);
        end
        OP_CLR: begin
          r_d     = '0;
          carry_d = 1'b0;
        end
        OP_ROL: begin
          r_d     = w_rol;
          carry_d = r_q[ACTIVE-1];
        end
        default: begin
          r_d     = r_q;
          carry_d = carry_q;
        end
      endcase
    end
  end

  // State register; zero follows the next-state value so it always matches Q.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_q     <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      r_q     <= r_d;
      carry_q <= carry_d;
      zero_q  <= (r_d == '0);
    end
  end

  generate
    if (ACTIVE == WIDTH) begin : g_no_pad
      assign Q = r_q;
    end else begin : g_pad
      assign Q = {{(WIDTH-ACTIVE){1'b0}}, r_q};
    end
  endgenerate

  assign carry = carry_q;
  assign zero  = zero_q;

  // Upper data bits are deliberately ignored on LOAD.
  logic unused_data;
  assign unused_data = ^data;

endmodule
`default_nettype wire
